// File: rtl/usb_fifo_bridge.sv
// Bridges an FT245-style synchronous USB FIFO chip to a pair of SoC FIFOs.
// Read/write bursts are arbitrated round-robin and bounded by BURST_MAX words.
module usb_fifo_bridge #(
  parameter int DW        = 8,
  parameter int BURST_MAX = 64,
  parameter int TURN_CYC  = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_full,
  output logic             rx_wr_en,
  output logic [DW-1:0]    rx_din,
  input  logic             tx_empty,
  output logic             tx_rd_en,
  input  logic [DW-1:0]    tx_dout,
  input  logic             rxf_n,
  output logic             oe_n,
  output logic             rd_n,
  input  logic             txe_n,
  output logic             wr_n,
  input  logic [DW-1:0]    ad_i,
  output logic [DW-1:0]    ad_o,
  output logic             ad_oe,
  output logic             busy,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] tx_cnt
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int GW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_OE,
    S_READ,
    S_WRITE,
    S_GAP
  } state_t;

  typedef enum logic {
    DIR_READ,
    DIR_WRITE
  } dir_t;

  state_t        state_q, state_d;
  dir_t          last_dir_q, last_dir_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [GW-1:0] gap_q, gap_d;

  logic rd_pend;
  logic wr_pend;
  logic beat_ok;
  logic beat_last;

  assign rd_pend   = ~rxf_n & ~rx_full;
  assign wr_pend   = ~txe_n & ~tx_empty;
  assign beat_ok   = (beat_q < BW'(BURST_MAX));
  assign beat_last = (beat_q == BW'(BURST_MAX - 1));
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_dir_q <= DIR_WRITE;
      beat_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_dir_q <= last_dir_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
    end
  end

  // Strobes are combinational on the pending flags so a flag change
  // suppresses the transfer in the very cycle it occurs.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    oe_n       = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    rx_wr_en   = 1'b0;
    tx_rd_en   = 1'b0;
    rx_din     = '0;
    ad_o       = '0;
    ad_oe      = 1'b0;

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        gap_d  = '0;
        if (rd_pend && wr_pend) begin
          state_d = (last_dir_q == DIR_WRITE) ? S_RD_OE : S_WRITE;
        end else if (rd_pend) begin
          state_d = S_RD_OE;
        end else if (wr_pend) begin
          state_d = S_WRITE;
        end
      end

      S_RD_OE: begin
        oe_n    = 1'b0;
        beat_d  = '0;
        state_d = S_READ;
      end

      S_READ: begin
        oe_n = 1'b0;
        if (rd_pend && beat_ok) begin
          rd_n     = 1'b0;
          rx_wr_en = 1'b1;
          rx_din   = ad_i;
          beat_d   = beat_q + BW'(1);
          if (beat_last) begin
            state_d    = S_GAP;
            last_dir_d = DIR_READ;
          end
        end else begin
          state_d    = S_GAP;
          last_dir_d = DIR_READ;
        end
      end

      S_WRITE: begin
        ad_oe = 1'b1;
        ad_o  = tx_dout;
        if (wr_pend && beat_ok) begin
          wr_n     = 1'b0;
          tx_rd_en = 1'b1;
          beat_d   = beat_q + BW'(1);
          if (beat_last) begin
            state_d    = S_GAP;
            last_dir_d = DIR_WRITE;
          end
        end else begin
          state_d    = S_GAP;
          last_dir_d = DIR_WRITE;
        end
      end

      S_GAP: begin
        if (gap_q == GW'(TURN_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_wr_en) rx_cnt <= rx_cnt + CNT_W'(1);
      if (tx_rd_en) tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Scoreboard bench for usb_fifo_bridge: a default-parameter instance and a
// small-burst/narrow-counter instance share one USB/FIFO model through a mux.
module tb_usb_fifo_bridge;

  logic clk;
  logic rst;
  logic sel;
  logic rx_full;
  logic tx_empty;
  logic rxf_n;
  logic txe_n;
  logic txe_hold;
  logic [7:0] ad_i;
  logic [7:0] tx_dout;

  logic a_rxf_n, a_txe_n, b_rxf_n, b_txe_n;
  assign a_rxf_n = sel ? 1'b1 : rxf_n;
  assign a_txe_n = sel ? 1'b1 : txe_n;
  assign b_rxf_n = sel ? rxf_n : 1'b1;
  assign b_txe_n = sel ? txe_n : 1'b1;

  logic        a_rx_wr_en, a_tx_rd_en, a_oe_n, a_rd_n, a_wr_n, a_ad_oe, a_busy;
  logic [7:0]  a_rx_din, a_ad_o;
  logic [31:0] a_rx_cnt, a_tx_cnt;
  logic        b_rx_wr_en, b_tx_rd_en, b_oe_n, b_rd_n, b_wr_n, b_ad_oe, b_busy;
  logic [7:0]  b_rx_din, b_ad_o;
  logic [3:0]  b_rx_cnt, b_tx_cnt;

  usb_fifo_bridge u_a (
    .clk(clk), .rst(rst),
    .rx_full(rx_full), .rx_wr_en(a_rx_wr_en), .rx_din(a_rx_din),
    .tx_empty(tx_empty), .tx_rd_en(a_tx_rd_en), .tx_dout(tx_dout),
    .rxf_n(a_rxf_n), .oe_n(a_oe_n), .rd_n(a_rd_n),
    .txe_n(a_txe_n), .wr_n(a_wr_n),
    .ad_i(ad_i), .ad_o(a_ad_o), .ad_oe(a_ad_oe),
    .busy(a_busy), .rx_cnt(a_rx_cnt), .tx_cnt(a_tx_cnt)
  );

  usb_fifo_bridge #(.DW(8), .BURST_MAX(4), .TURN_CYC(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst),
    .rx_full(rx_full), .rx_wr_en(b_rx_wr_en), .rx_din(b_rx_din),
    .tx_empty(tx_empty), .tx_rd_en(b_tx_rd_en), .tx_dout(tx_dout),
    .rxf_n(b_rxf_n), .oe_n(b_oe_n), .rd_n(b_rd_n),
    .txe_n(b_txe_n), .wr_n(b_wr_n),
    .ad_i(ad_i), .ad_o(b_ad_o), .ad_oe(b_ad_oe),
    .busy(b_busy), .rx_cnt(b_rx_cnt), .tx_cnt(b_tx_cnt)
  );

  logic        m_rx_wr_en, m_tx_rd_en, m_oe_n, m_rd_n, m_wr_n, m_ad_oe, m_busy;
  logic [7:0]  m_rx_din, m_ad_o;
  logic [31:0] m_rx_cnt, m_tx_cnt;
  assign m_rx_wr_en = sel ? b_rx_wr_en : a_rx_wr_en;
  assign m_tx_rd_en = sel ? b_tx_rd_en : a_tx_rd_en;
  assign m_oe_n     = sel ? b_oe_n     : a_oe_n;
  assign m_rd_n     = sel ? b_rd_n     : a_rd_n;
  assign m_wr_n     = sel ? b_wr_n     : a_wr_n;
  assign m_ad_oe    = sel ? b_ad_oe    : a_ad_oe;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_rx_din   = sel ? b_rx_din   : a_rx_din;
  assign m_ad_o     = sel ? b_ad_o     : a_ad_o;
  assign m_rx_cnt   = sel ? {28'b0, b_rx_cnt} : a_rx_cnt;
  assign m_tx_cnt   = sel ? {28'b0, b_tx_cnt} : a_tx_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] host_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int blen[$];
  int bdir[$];
  int gaps[$];
  int n_assert = 0;
  int n_fail   = 0;
  int busy_cyc, oe_only, prev_dir, idle_run, rx_seen, tx_seen, full_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    rxf_n    = (host_q.size() == 0);
    ad_i     = (host_q.size() != 0) ? host_q[0] : 8'h00;
    tx_empty = (tx_q.size() == 0);
    tx_dout  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    txe_n    = txe_hold;
  endtask

  task automatic push_host(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom_range(1, 255));
      host_q.push_back(w);
      exp_rx.push_back(w);
    end
    drive_inputs();
  endtask

  task automatic push_tx(input int n);
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom_range(1, 255));
      tx_q.push_back(w);
      exp_tx.push_back(w);
    end
    drive_inputs();
  endtask

  task automatic clear_log();
    blen.delete();
    bdir.delete();
    gaps.delete();
    busy_cyc = 0;
    oe_only  = 0;
    prev_dir = 0;
    idle_run = 0;
    rx_seen  = 0;
    tx_seen  = 0;
  endtask

  // One bus cycle: sample and score mid-cycle, then let the chip/FIFO model
  // consume the transferred word just after the rising edge.
  task automatic cycle();
    logic s_rx, s_tx;
    int   cur;
    @(negedge clk);
    check("oe_overlap", 32'(m_ad_oe & ~m_oe_n), 32'd0);
    check("rx_strobe_no_pend", 32'(m_rx_wr_en & (rxf_n | rx_full)), 32'd0);
    check("tx_strobe_no_pend", 32'(m_tx_rd_en & (txe_n | tx_empty)), 32'd0);
    s_rx = m_rx_wr_en;
    s_tx = m_tx_rd_en;
    if (s_rx) begin
      check("rd_n_low", 32'(m_rd_n), 32'd0);
      if (exp_rx.size() == 0) check("rx_extra_word", 32'd1, 32'd0);
      else check("rx_data", 32'(m_rx_din), 32'(exp_rx.pop_front()));
    end
    if (s_tx) begin
      check("wr_n_low", 32'(m_wr_n), 32'd0);
      if (exp_tx.size() == 0) check("tx_extra_word", 32'd1, 32'd0);
      else check("tx_data", 32'(m_ad_o), 32'(exp_tx.pop_front()));
    end
    busy_cyc += int'(m_busy);
    if (!m_oe_n && m_rd_n) oe_only++;
    cur = s_rx ? 1 : (s_tx ? 2 : 0);
    if (cur != 0) begin
      if (prev_dir == cur) begin
        blen[blen.size()-1]++;
      end else begin
        if (bdir.size() != 0) gaps.push_back(idle_run);
        blen.push_back(1);
        bdir.push_back(cur);
      end
      idle_run = 0;
    end else begin
      idle_run++;
    end
    prev_dir = cur;
    @(posedge clk);
    #1;
    if (s_rx && host_q.size() != 0) begin
      host_q.delete(0);
      rx_seen++;
      if (full_after > 0 && rx_seen == full_after) rx_full = 1'b1;
    end
    if (s_tx && tx_q.size() != 0) begin
      tx_q.delete(0);
      tx_seen++;
    end
    drive_inputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    sel        = 1'b0;
    rst        = 1'b1;
    rx_full    = 1'b0;
    txe_hold   = 1'b0;
    full_after = 0;
    clear_log();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset values, default instance
    check("rst_oe_n", 32'(m_oe_n), 32'd1);
    check("rst_rd_n", 32'(m_rd_n), 32'd1);
    check("rst_wr_n", 32'(m_wr_n), 32'd1);
    check("rst_rx_wr_en", 32'(m_rx_wr_en), 32'd0);
    check("rst_tx_rd_en", 32'(m_tx_rd_en), 32'd0);
    check("rst_ad_oe", 32'(m_ad_oe), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_rx_cnt", m_rx_cnt, 32'd0);
    check("rst_tx_cnt", m_tx_cnt, 32'd0);

    // Contention on the small-burst instance, both sides pending from reset
    sel = 1'b1;
    push_host(12);
    push_tx(12);
    #1;
    check("rst_pend_busy", 32'(m_busy), 32'd0);
    check("rst_pend_rd_n", 32'(m_rd_n), 32'd1);
    check("rst_pend_wr_n", 32'(m_wr_n), 32'd1);
    check("rst_pend_ad_oe", 32'(m_ad_oe), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    run_cycles(80);
    check("cont_bursts", 32'(bdir.size()), 32'd6);
    for (int i = 0; i < bdir.size(); i++) begin
      check($sformatf("cont_dir%0d", i), 32'(bdir[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("cont_len%0d", i), 32'(blen[i]), 32'd4);
    end
    check("cont_rx_left", 32'(exp_rx.size()), 32'd0);
    check("cont_tx_left", 32'(exp_tx.size()), 32'd0);
    check("cont_rx_cnt", m_rx_cnt, 32'd12);
    check("cont_tx_cnt", m_tx_cnt, 32'd12);

    // Burst cap: 10 words in bursts of 4,4,2 with 2 GAP + 1 IDLE between
    clear_log();
    push_tx(10);
    run_cycles(40);
    check("cap_bursts", 32'(blen.size()), 32'd3);
    if (blen.size() == 3) begin
      check("cap_len0", 32'(blen[0]), 32'd4);
      check("cap_len1", 32'(blen[1]), 32'd4);
      check("cap_len2", 32'(blen[2]), 32'd2);
      check("cap_gap0", 32'(gaps[0]), 32'd3);
      check("cap_gap1", 32'(gaps[1]), 32'd3);
      check("cap_dir2", 32'(bdir[2]), 32'd2);
    end
    check("cap_tx_left", 32'(exp_tx.size()), 32'd0);
    check("cap_tx_cnt", m_tx_cnt, 32'd6);

    // Counter wrap: 4-bit counter after 17 reads
    rst = 1'b1;
    #1;
    check("wrap_rst_rx_cnt", m_rx_cnt, 32'd0);
    check("wrap_rst_tx_cnt", m_tx_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_log();
    push_host(17);
    run_cycles(70);
    check("wrap_bursts", 32'(blen.size()), 32'd5);
    check("wrap_rx_left", 32'(exp_rx.size()), 32'd0);
    check("wrap_rx_cnt", m_rx_cnt, 32'd1);

    // Plain read burst on the default instance
    sel = 1'b0;
    drive_inputs();
    clear_log();
    push_host(5);
    run_cycles(20);
    check("rd_bursts", 32'(blen.size()), 32'd1);
    if (blen.size() == 1) begin
      check("rd_len", 32'(blen[0]), 32'd5);
      check("rd_dir", 32'(bdir[0]), 32'd1);
    end
    check("rd_busy_cycles", 32'(busy_cyc), 32'd8);
    check("rd_oe_only_cycles", 32'(oe_only), 32'd2);
    check("rd_rx_left", 32'(exp_rx.size()), 32'd0);
    check("rd_rx_cnt", m_rx_cnt, 32'd5);

    // Back-pressure: rx_full rises after the third word
    clear_log();
    full_after = 3;
    push_host(6);
    run_cycles(20);
    check("bp_bursts", 32'(blen.size()), 32'd1);
    if (blen.size() == 1) check("bp_len", 32'(blen[0]), 32'd3);
    check("bp_host_left", 32'(host_q.size()), 32'd3);
    check("bp_busy", 32'(m_busy), 32'd0);
    check("bp_rx_cnt", m_rx_cnt, 32'd8);
    full_after = 0;
    rx_full    = 1'b0;
    drive_inputs();
    clear_log();
    run_cycles(20);
    check("bp2_bursts", 32'(blen.size()), 32'd1);
    if (blen.size() == 1) check("bp2_len", 32'(blen[0]), 32'd3);
    check("bp2_rx_left", 32'(exp_rx.size()), 32'd0);
    check("bp2_rx_cnt", m_rx_cnt, 32'd11);

    // Reset mid-WRITE after two words
    clear_log();
    push_tx(6);
    for (int i = 0; i < 20 && tx_seen < 2; i++) cycle();
    check("mw_words_before_rst", 32'(tx_seen), 32'd2);
    check("mw_strobe_before_rst", 32'(m_tx_rd_en), 32'd1);
    check("mw_tx_cnt_before_rst", m_tx_cnt, 32'd2);
    rst = 1'b1;
    #1;
    check("mw_tx_rd_en", 32'(m_tx_rd_en), 32'd0);
    check("mw_wr_n", 32'(m_wr_n), 32'd1);
    check("mw_oe_n", 32'(m_oe_n), 32'd1);
    check("mw_ad_oe", 32'(m_ad_oe), 32'd0);
    check("mw_busy", 32'(m_busy), 32'd0);
    check("mw_rx_cnt", m_rx_cnt, 32'd0);
    check("mw_tx_cnt", m_tx_cnt, 32'd0);
    tx_q.delete();
    exp_tx.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_cycles(5);
    check("mw_idle_after", 32'(m_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_fifo_bridge.md
USB_FIFO_BRIDGE -- requirements
Module: usb_fifo_bridge

Interface
REQ-001 SHALL have parameter DW, default 8, meaning USB data bus and FIFO word width in bits (8 or 16).
REQ-002 SHALL have parameter BURST_MAX, default 64, meaning max words moved per grant before re-arbitration (>=1).
REQ-003 SHALL have parameter TURN_CYC, default 1, meaning idle bus-turnaround cycles after every burst (>=1).
REQ-004 SHALL have parameter CNT_W, default 32, meaning width of the transferred-word counters.
REQ-005 Ports (name direction width meaning):
  clk        in  1       single clock, all logic rising-edge
  rst        in  1       asynchronous, active-high reset
  rx_full    in  1       host->SoC FIFO full
  rx_wr_en   out 1       host->SoC FIFO write strobe
  rx_din     out DW      host->SoC FIFO write data
  tx_empty   in  1       SoC->host FIFO empty
  tx_rd_en   out 1       SoC->host FIFO read strobe (first-word-fall-through)
  tx_dout    in  DW      SoC->host FIFO head word
  rxf_n      in  1       USB chip has data for SoC, active-low
  oe_n       out 1       USB chip bus output enable, active-low
  rd_n       out 1       USB chip read strobe, active-low
  txe_n      in  1       USB chip can accept data, active-low
  wr_n       out 1       USB chip write strobe, active-low
  ad_i       in  DW      USB data bus, input half
  ad_o       out DW      USB data bus, output half
  ad_oe      out 1       drive enable for ad_o (pad tristate outside block)
  busy       out 1       state != IDLE
  rx_cnt     out CNT_W   words transferred host->SoC
  tx_cnt     out CNT_W   words transferred SoC->host

Function
REQ-006 SHALL implement states IDLE, RD_OE, READ, WRITE, GAP in a registered FSM.
REQ-007 rd_pend = ~rxf_n & ~rx_full; wr_pend = ~txe_n & ~tx_empty.
REQ-008 IDLE: only rd_pend -> RD_OE; only wr_pend -> WRITE; both -> direction opposite to last_dir register; neither -> IDLE.
REQ-009 RD_OE: SHALL drive oe_n=0, rd_n=1, ad_oe=0 for exactly one cycle, then -> READ.
REQ-010 READ: oe_n=0; rd_n=0, rx_wr_en=1, rx_din=ad_i in the same cycle iff rd_pend & beat<BURST_MAX (zero-latency capture).
REQ-011 WRITE: ad_oe=1, ad_o=tx_dout; wr_n=0, tx_rd_en=1 in the same cycle iff wr_pend & beat<BURST_MAX.
REQ-012 beat counter SHALL clear on entry to READ/WRITE and increment on each strobed word; width clog2(BURST_MAX+1).
REQ-013 READ/WRITE SHALL exit to GAP the cycle after a non-strobed cycle or when beat reaches BURST_MAX; last_dir SHALL be updated on exit.
REQ-014 GAP: all strobes inactive, oe_n=1, ad_oe=0 for TURN_CYC cycles, then -> IDLE.
REQ-015 ad_oe SHALL never be 1 while oe_n=0, in any cycle.
REQ-016 rx_cnt/tx_cnt SHALL increment by 1 on each rx_wr_en/tx_rd_en cycle and wrap from 2^CNT_W-1 to 0.
REQ-017 rxf_n, txe_n, rx_full or tx_empty changing mid-burst SHALL suppress the strobe in that same cycle; no word SHALL be lost or duplicated.
REQ-018 Outside READ, rx_din SHALL be 0; outside WRITE, ad_o SHALL be 0.

Reset
REQ-019 rst=1 SHALL asynchronously force state=IDLE, last_dir=WRITE, beat=0, rx_cnt=tx_cnt=0, busy=0.
REQ-020 During reset: oe_n=rd_n=wr_n=1, rx_wr_en=tx_rd_en=0, ad_oe=0, including reset asserted mid-burst.
REQ-021 After release, first arbitration with both pending SHALL grant READ.

Verification
REQ-022 Read burst: rxf_n=0 for 5 words, rx_full=0 -> RD_OE 1 cycle, 5 rx_wr_en pulses with ad_i values, GAP, rx_cnt=5.
REQ-023 Burst cap: BURST_MAX=4, tx FIFO holds 10, txe_n=0 -> writes 4,4,2 separated by TURN_CYC GAP cycles, tx_cnt=10.
REQ-024 Contention: rd_pend and wr_pend held continuously -> grants alternate READ, WRITE, READ; ad_oe and ~oe_n never overlap.
REQ-025 Back-pressure: rx_full rises after 3 words -> exactly 3 writes, no strobe in the rx_full cycle, -> GAP.
REQ-026 Reset mid-WRITE after 2 words -> strobes drop same cycle, counters 0, busy=0, ad_oe=0.
REQ-027 Wrap: CNT_W=4, 17 read words -> rx_cnt=1.
